// File: rtl/seq_alu.sv
// Sequential 64-bit ALU. Logic and arithmetic operations finish in one cycle.
// Shifts move one bit per cycle, and the result is flagged with done, zero and err.
module seq_alu (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [3:0]  alu_type,
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic [5:0]  shamt,
    output logic        busy,
    output logic        done,
    output logic [63:0] result,
    output logic        zero,
    output logic        err
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    // Returns {unsupported, value}. For shifts the value is the unshifted operand.
    function automatic logic [64:0] alu_eval(input logic [3:0] op, input logic [63:0] x,
                                             input logic [63:0] y);
        logic [64:0] r;
        case (op)
            4'b0000: r = {1'b0, x & y};
            4'b0001: r = {1'b0, x | y};
            4'b0010: r = {1'b0, x + y};
            4'b0110: r = {1'b0, x - y};
            4'b1111: r = {1'b0, y};
            4'b0011: r = {1'b0, x};
            4'b0111: r = {1'b0, x};
            default: r = {1'b1, 64'd0};
        endcase
        return r;
    endfunction

    logic [1:0]  state_r;
    logic [1:0]  state_next_s;
    logic [5:0]  count_r;
    logic [5:0]  count_next_s;
    logic [63:0] result_r;
    logic [63:0] result_next_s;
    logic        err_r;
    logic        err_next_s;
    logic        shift_left_r;
    logic        shift_left_next_s;
    logic        zero_r;
    logic        busy_r;
    logic        done_r;
    logic        is_shift_s;

    assign is_shift_s = (alu_type == 4'b0011) || (alu_type == 4'b0111);

    // Next-state and datapath decode
    always_comb begin
        state_next_s      = state_r;
        count_next_s      = count_r;
        result_next_s     = result_r;
        err_next_s        = err_r;
        shift_left_next_s = shift_left_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    {err_next_s, result_next_s} = alu_eval(alu_type, a, b);
                    shift_left_next_s = (alu_type == 4'b0011);
                    if (is_shift_s && (shamt != 6'd0)) begin
                        count_next_s = shamt;
                        state_next_s = SHIFT;
                    end else begin
                        count_next_s = 6'd0;
                        state_next_s = DONE;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            SHIFT: begin
                if (shift_left_r) begin
                    result_next_s = {result_r[62:0], 1'b0};
                end else begin
                    result_next_s = {1'b0, result_r[63:1]};
                end
                count_next_s = count_r - 6'd1;
                if (count_r == 6'd1) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = SHIFT;
                end
            end
            DONE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // State and output registers. busy and done are registered from the next state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= IDLE;
            count_r      <= 6'd0;
            result_r     <= 64'd0;
            err_r        <= 1'b0;
            shift_left_r <= 1'b0;
            zero_r       <= 1'b1;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            count_r      <= count_next_s;
            result_r     <= result_next_s;
            err_r        <= err_next_s;
            shift_left_r <= shift_left_next_s;
            zero_r       <= (result_next_s == 64'd0);
            busy_r       <= (state_next_s != IDLE);
            done_r       <= (state_next_s == DONE);
        end
    end

    assign busy   = busy_r;
    assign done   = done_r;
    assign result = result_r;
    assign zero   = zero_r;
    assign err    = err_r;

endmodule
